// File: rtl/bridge_cmd_decoder.sv
// Remote-side UART bridge command decoder: queues received frames and replays them
// as master requests, returning read data to the UART TX. Optional macro: BRIDGE_RD_TIMEOUT_EN.
module bridge_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [DATA_WIDTH+ADDR_WIDTH:0]      frame_in,
  input  logic                                frame_ready,
  output logic                                mreq,
  output logic                                mwrite,
  output logic [ADDR_WIDTH-1:0]               maddr,
  output logic [DATA_WIDTH-1:0]               mwdata,
  input  logic                                mack,
  input  logic [DATA_WIDTH-1:0]               mrdata,
  input  logic                                mrvalid,
  output logic [DATA_WIDTH-1:0]               tx_data,
  output logic                                tx_en,
  input  logic                                tx_busy,
  output logic                                busy,
  output logic                                ovf,
  output logic                                rd_timeout
);
  localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, SEND, SEND_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [FW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                    prev_ready_q;
  logic                    mreq_q, mreq_d, mwrite_q, mwrite_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0]   mwdata_q, mwdata_d, tx_data_q, tx_data_d;
  logic                    tx_en_q, tx_en_d, busy_q, busy_d, ovf_q, ovf_d;
  logic                    guard_q, guard_d;
  logic                    push, pop, accept, full, empty;
  logic [FW-1:0]           head;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push   = frame_ready && !prev_ready_q;
  assign pop    = (state_q == IDLE) && !empty;
  assign accept = push && (!full || pop);
  assign head   = mem_q[rd_ptr_q[PW-1:0]];

`ifdef BRIDGE_RD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_to_q, rd_to_d;
`endif

  always_comb begin
    state_d   = state_q;
    mreq_d    = mreq_q;
    mwrite_d  = mwrite_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    guard_d   = guard_q;
    ovf_d     = ovf_q || (push && full && !pop);
    wr_ptr_d  = wr_ptr_q + (PW+1)'(accept);
    rd_ptr_d  = rd_ptr_q + (PW+1)'(pop);
`ifdef BRIDGE_RD_TIMEOUT_EN
    cnt_d     = cnt_q;
    rd_to_d   = rd_to_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          {mwrite_d, mwdata_d, maddr_d} = head;
          mreq_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mack) begin
          mreq_d = 1'b0;
          if (mwrite_q) begin
            state_d = IDLE;
          end else if (mrvalid) begin
            tx_data_d = mrdata;
            state_d   = SEND;
          end else begin
            state_d = WAIT_RD;
`ifdef BRIDGE_RD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT_RD: begin
        if (mrvalid) begin
          tx_data_d = mrdata;
          state_d   = SEND;
`ifdef BRIDGE_RD_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // Answer with all-ones so the remote requester is never left hanging.
          tx_data_d = '1;
          rd_to_d   = 1'b1;
          state_d   = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_en_d = 1'b1;
          guard_d = 1'b1;
          state_d = SEND_WAIT;
        end
      end
      SEND_WAIT: begin
        // TX busy may lag the start pulse by a cycle, so the first cycle is skipped.
        if (guard_q)       guard_d = 1'b0;
        else if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      prev_ready_q <= 1'b0;
      mreq_q       <= 1'b0;
      mwrite_q     <= 1'b0;
      maddr_q      <= '0;
      mwdata_q     <= '0;
      tx_data_q    <= '0;
      tx_en_q      <= 1'b0;
      guard_q      <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef BRIDGE_RD_TIMEOUT_EN
      cnt_q        <= '0;
      rd_to_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      prev_ready_q <= frame_ready;
      mreq_q       <= mreq_d;
      mwrite_q     <= mwrite_d;
      maddr_q      <= maddr_d;
      mwdata_q     <= mwdata_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      guard_q      <= guard_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
`ifdef BRIDGE_RD_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rd_to_q      <= rd_to_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[PW-1:0]] <= frame_in;
  end

  assign mreq    = mreq_q;
  assign mwrite  = mwrite_q;
  assign maddr   = maddr_q;
  assign mwdata  = mwdata_q;
  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
`ifdef BRIDGE_RD_TIMEOUT_EN
  assign rd_timeout = rd_to_q;
`else
  assign rd_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bridge_cmd_decoder.sv
// Scoreboard bench for bridge_cmd_decoder: expected requests and TX bytes are queued
// as stimulus is driven and checked when the DUT accepts a request or pulses tx_en.
module tb_bridge_cmd_decoder;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int FW = DW + AW + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [FW-1:0] frame_in = '0;
  logic          frame_ready = 1'b0;
  logic          mreq, mwrite;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic          mack = 1'b0;
  logic [DW-1:0] mrdata = '0;
  logic          mrvalid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_en;
  logic          tx_busy = 1'b0;
  logic          busy, ovf, rd_timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [FW-1:0] req_q[$];
  logic [DW-1:0] tx_q[$];
  logic [FW-1:0] exp_req;
  logic [DW-1:0] exp_tx;

  bridge_cmd_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .frame_in(frame_in), .frame_ready(frame_ready),
    .mreq(mreq), .mwrite(mwrite), .maddr(maddr), .mwdata(mwdata), .mack(mack),
    .mrdata(mrdata), .mrvalid(mrvalid), .tx_data(tx_data), .tx_en(tx_en),
    .tx_busy(tx_busy), .busy(busy), .ovf(ovf), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs change #1 after posedge, so the falling edge sees settled values.
  always @(negedge clk) begin
    if (rstn && mreq && mack) begin
      n_cmp++;
      if (req_q.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got %h required none", {mwrite, mwdata, maddr});
      end else begin
        exp_req = req_q.pop_front();
        if ({mwrite, mwdata, maddr} !== exp_req) begin
          n_err++;
          $display("FAIL req_fields: got %h required %h", {mwrite, mwdata, maddr}, exp_req);
        end
      end
    end
    if (rstn && tx_en) begin
      n_cmp++;
      if (tx_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %h required none", tx_data);
      end else begin
        exp_tx = tx_q.pop_front();
        if (tx_data !== exp_tx) begin
          n_err++;
          $display("FAIL tx_data: got %h required %h", tx_data, exp_tx);
        end
      end
    end
  end

  task automatic send_frame(input logic [FW-1:0] f);
    @(posedge clk); #1;
    frame_in = f;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic wait_mreq(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (mreq) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    mack = 1'b0; mrvalid = 1'b0; tx_busy = 1'b0; frame_ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({mreq, mwrite, maddr, mwdata, tx_data, tx_en, busy, ovf, rd_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0",
               {mreq, mwrite, maddr, mwdata, tx_data, tx_en, busy, ovf, rd_timeout});
    end
    rstn = 1'b1;
  endtask

  task automatic test_write();
    bit ok;
    mack = 1'b1;
    req_q.push_back(21'h1A5123);
    send_frame(21'h1A5123);
    n_cmp++;
    if (mreq !== 1'b0) begin n_err++; $display("FAIL wr_mreq_T1: got %b required 0", mreq); end
    @(posedge clk); #1;
    n_cmp++;
    if ({mreq, mwrite, maddr, mwdata} !== {1'b1, 1'b1, 12'h123, 8'hA5}) begin
      n_err++;
      $display("FAIL wr_req_T2: got %b %b %h %h required 1 1 123 a5", mreq, mwrite, maddr, mwdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({mreq, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL wr_turnaround: got mreq=%b busy=%b required 0 0", mreq, busy);
    end
    // A level held high must enqueue exactly once.
    req_q.push_back(21'h1BB0AA);
    @(posedge clk); #1;
    frame_in = 21'h1BB0AA;
    frame_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 frame_ready = 1'b0;
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || req_q.size() != 0) begin
      n_err++;
      $display("FAIL wr_level: got idle=%0d pending=%0d required 1 0", ok, req_q.size());
    end
  endtask

  task automatic test_read();
    bit ok;
    mack = 1'b0;
    req_q.push_back(21'h000456);
    tx_q.push_back(8'h3C);
    send_frame(21'h000456);
    wait_mreq(10, ok);
    n_cmp++;
    if (!ok || mwrite !== 1'b0 || maddr !== 12'h456) begin
      n_err++;
      $display("FAIL rd_req: got ok=%0d mwrite=%b maddr=%h required 1 0 456", ok, mwrite, maddr);
    end
    @(posedge clk); #1 mack = 1'b1;
    @(posedge clk); #1 mack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 mrvalid = 1'b1; mrdata = 8'h3C;
    @(posedge clk); #1 mrvalid = 1'b0; mrdata = 8'h00;
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || tx_q.size() != 0 || req_q.size() != 0) begin
      n_err++;
      $display("FAIL rd_done: got idle=%0d tx_pending=%0d required 1 0", ok, tx_q.size());
    end
  endtask

  task automatic test_read_fast();
    bit ok;
    req_q.push_back(21'h0009AB);
    tx_q.push_back(8'h5A);
    send_frame(21'h0009AB);
    wait_mreq(10, ok);
    mack = 1'b1; mrvalid = 1'b1; mrdata = 8'h5A;
    @(posedge clk); #1 mack = 1'b0; mrvalid = 1'b0;
    n_cmp++;
    if (tx_en !== 1'b0) begin n_err++; $display("FAIL fast_tx_early: got %b required 0", tx_en); end
    @(posedge clk); #1;
    n_cmp++;
    if (!ok || tx_en !== 1'b1 || tx_data !== 8'h5A) begin
      n_err++;
      $display("FAIL fast_tx_timing: got tx_en=%b data=%h required 1 5a", tx_en, tx_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tx_en !== 1'b0) begin n_err++; $display("FAIL fast_tx_pulse: got %b required 0", tx_en); end
    // Stray read data while idle must not produce a response.
    wait_idle(10, ok);
    mrvalid = 1'b1; mrdata = 8'hEE;
    @(posedge clk); #1 mrvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int pulses;
    tx_busy = 1'b1;
    req_q.push_back(21'h000321);
    tx_q.push_back(8'hC3);
    send_frame(21'h000321);
    wait_mreq(10, ok);
    mack = 1'b1; mrvalid = 1'b1; mrdata = 8'hC3;
    @(posedge clk); #1 mack = 1'b0; mrvalid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (tx_en) pulses++;
    end
    n_cmp++;
    if (!ok || pulses != 0) begin
      n_err++;
      $display("FAIL bp_held: got %0d pulses required 0", pulses);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (tx_en) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got %0d pulses busy=%b required 1 0", pulses, busy);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    mack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [FW-1:0] f;
      f = {1'b1, 8'(8'h20 + i), 12'(12'h010 + i)};
      if (i < 5) req_q.push_back(f);
      send_frame(f);
    end
    n_cmp++;
    if ({ovf, busy, mreq, maddr} !== {1'b1, 1'b1, 1'b1, 12'h010}) begin
      n_err++;
      $display("FAIL ovf_state: got ovf=%b busy=%b mreq=%b maddr=%h required 1 1 1 010",
               ovf, busy, mreq, maddr);
    end
    mack = 1'b1;
    wait_idle(40, ok);
    n_cmp++;
    if (!ok || req_q.size() != 0 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drain: got idle=%0d pending=%0d ovf=%b required 1 0 1", ok, req_q.size(), ovf);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    mack = 1'b0;
    req_q.push_back(21'h000ABC);
    send_frame(21'h000ABC);
    wait_mreq(10, ok);
    mack = 1'b1;
    @(posedge clk); #1 mack = 1'b0;
`ifdef BRIDGE_RD_TIMEOUT_EN
    tx_q.push_back(8'hFF);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (tx_en) begin k = i; break; end
    end
    n_cmp++;
    if (!ok || k != 17 || rd_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout: got cycle=%0d rd_timeout=%b required 17 1", k, rd_timeout);
    end
    wait_idle(10, ok);
`else
    k = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (tx_en) k++;
    end
    n_cmp++;
    if (!ok || k != 0 || busy !== 1'b1 || mreq !== 1'b0 || rd_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL no_timeout: got pulses=%0d busy=%b mreq=%b rd_timeout=%b required 0 1 0 0",
               k, busy, mreq, rd_timeout);
    end
    apply_reset();
`endif
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    mack = 1'b0;
    send_frame(21'h000777);
    wait_mreq(10, ok);
    send_frame(21'h1110AA);
    send_frame(21'h1220BB);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (!ok || {mreq, mwrite, maddr, mwdata, tx_data, tx_en, busy, ovf, rd_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got %h required 0",
               {mreq, mwrite, maddr, mwdata, tx_data, tx_en, busy, ovf, rd_timeout});
    end
    rstn = 1'b1;
    mack = 1'b1;
    req_q.push_back(21'h1CD321);
    send_frame(21'h1CD321);
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || req_q.size() != 0 || tx_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_recover: got idle=%0d pending=%0d required 1 0", ok, req_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_fast();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_reset_mid_read();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
